// File: rtl/trace_pkg.sv
// Shared definitions for the retire trace buffer: default datapath width,
// halt detector state encoding and drop counter width.
package trace_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned DROP_W   = 16;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

endpackage

// File: rtl/trace_fifo.sv
// Trace entry FIFO: DEPTH x WIDTH storage with wrapping pointers, an
// occupancy count and a registered head entry (no fall-through).
module trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_req,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             full;
  logic             pop;
  logic             push;

  // Accept/drop decision, next pointers and next head entry.
  // The head is registered, so when the entry being written this edge is
  // about to become the head it is taken from wdata rather than the array.
  always_comb begin
    full       = (count == FULL_CNT);
    pop        = rd_valid && rd_ready;
    push       = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_nxt  = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    head_nxt   = rdata;
    if (push && (rd_ptr_nxt == wr_ptr)) begin
      head_nxt = wdata;
    end else if (count_nxt != '0) begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  // Pointer, occupancy and head register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rdata    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      rd_valid <= (count_nxt != '0);
      rdata    <= head_nxt;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: captures (PC, result) of each newly retired
// instruction into a FIFO, tracks dropped captures and detects a halted
// core by watching for a PC that stays the same for HALT_CYCLES samples.
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter int unsigned HALT_CYCLES = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [XLEN-1:0]          currentpc,
  input  logic [XLEN-1:0]          MemtoRegOut,
  input  logic                     capture_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count,
  output logic                     halted
);

  localparam int unsigned SW = $clog2(HALT_CYCLES) + 1;
  localparam logic [SW-1:0] STALL_MAX = SW'(HALT_CYCLES - 1);

  logic [XLEN-1:0]   prev_pc;
  logic              first_smp;
  logic              same_pc;
  logic              push_req;
  logic              drop;
  logic [SW-1:0]     stall_cnt;
  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [2*XLEN-1:0] head;

  // Capture filter: push on the first sample or whenever the PC moves.
  always_comb begin
    same_pc  = !first_smp && (currentpc == prev_pc);
    push_req = capture_en && !same_pc;
  end

  // Remember the previous sample's PC for the filter and halt detector.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      prev_pc   <= '0;
      first_smp <= 1'b1;
    end else begin
      prev_pc   <= currentpc;
      first_smp <= 1'b0;
    end
  end

  // Count consecutive repeats of the same PC, saturating at the halt threshold.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (same_pc) begin
      if (stall_cnt != STALL_MAX) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end else begin
      stall_cnt <= '0;
    end
  end

  // Halt detector next state: HALT is sticky until reset.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (stall_cnt == STALL_MAX) state_nxt = ST_HALT;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase
  end

  // Halt detector state and its registered flag.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state  <= ST_RUN;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == ST_HALT);
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk      (CLK),
    .rst      (reset),
    .push_req (push_req),
    .wdata    ({currentpc, MemtoRegOut}),
    .rd_ready (out_ready),
    .rd_valid (out_valid),
    .rdata    (head),
    .count    (count),
    .drop     (drop)
  );

  assign out_pc   = head[2*XLEN-1:XLEN];
  assign out_data = head[XLEN-1:0];

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer (DEPTH=8, XLEN=64, HALT_CYCLES=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_retire_trace_buffer;

  localparam int unsigned DEPTH       = 8;
  localparam int unsigned XLEN        = 64;
  localparam int unsigned HALT_CYCLES = 4;

  logic            CLK = 1'b0;
  logic            reset = 1'b1;
  logic [XLEN-1:0] currentpc = '0;
  logic [XLEN-1:0] MemtoRegOut = '0;
  logic            capture_en = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_data;
  logic [3:0]      count;
  logic            overflow;
  logic [15:0]     drop_count;
  logic            halted;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  retire_trace_buffer #(
    .DEPTH       (DEPTH),
    .XLEN        (XLEN),
    .HALT_CYCLES (HALT_CYCLES)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .currentpc   (currentpc),
    .MemtoRegOut (MemtoRegOut),
    .capture_en  (capture_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_data    (out_data),
    .count       (count),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .halted      (halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp(input logic [63:0] pc, input logic [63:0] d);
    currentpc   = pc;
    MemtoRegOut = d;
    step();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_ovf"},   64'(overflow), 64'd0);
    check({tag, "_drops"}, 64'(drop_count), 64'd0);
    check({tag, "_halt"},  64'(halted), 64'd0);
    check({tag, "_pc"},    out_pc, 64'd0);
    check({tag, "_data"},  out_data, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    apply_reset();
    check_zero("rst");

    // Sequential PCs with immediate consumption
    capture_en = 1'b1;
    out_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp(64'(4 * i), 64'(i + 1));
      check("seq_valid", 64'(out_valid), 64'd1);
      check("seq_pc",    out_pc, 64'(4 * i));
      check("seq_data",  out_data, 64'(i + 1));
      check("seq_count", 64'(count), 64'd1);
    end
    smp(64'hC, 64'h5);
    check("seq_empty_valid", 64'(out_valid), 64'd0);
    check("seq_empty_count", 64'(count), 64'd0);
    check("seq_hold_pc",     out_pc, 64'hC);
    check("seq_hold_data",   out_data, 64'h4);
    check("seq_ovf",         64'(overflow), 64'd0);

    // Fill past capacity with no consumer
    apply_reset();
    capture_en = 1'b1;
    out_ready  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      smp(64'h100 + 64'(4 * i), 64'h10 + 64'(i));
    end
    check("full_count", 64'(count), 64'd8);
    check("full_ovf",   64'(overflow), 64'd1);
    check("full_drops", 64'(drop_count), 64'd2);
    check("full_pc",    out_pc, 64'h100);
    check("full_data",  out_data, 64'h10);

    // Push and pop on the same edge while full
    out_ready = 1'b1;
    smp(64'h200, 64'hAA);
    check("pp_count", 64'(count), 64'd8);
    check("pp_drops", 64'(drop_count), 64'd2);
    check("pp_ovf",   64'(overflow), 64'd1);
    check("pp_pc",    out_pc, 64'h104);
    check("pp_data",  out_data, 64'h11);

    // Drain in FIFO order (PC held so nothing new is pushed)
    for (int k = 0; k < 8; k++) begin
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_pc",   out_pc,   (k < 7) ? 64'h104 + 64'(4 * k) : 64'h200);
      check("drain_data", out_data, (k < 7) ? 64'h11 + 64'(k) : 64'hAA);
      smp(64'h200, 64'h0);
    end
    check("drain_end_valid", 64'(out_valid), 64'd0);
    check("drain_end_count", 64'(count), 64'd0);
    check("drain_end_drops", 64'(drop_count), 64'd2);

    // Halt on a PC stuck for HALT_CYCLES samples
    apply_reset();
    capture_en = 1'b1;
    out_ready  = 1'b0;
    smp(64'h10, 64'h1);
    for (int j = 0; j < 4; j++) begin
      smp(64'h30, 64'h33);
      check("stall_halt", 64'(halted), 64'd0);
    end
    check("stall_count", 64'(count), 64'd2);
    smp(64'h40, 64'h44);
    check("halt_set",   64'(halted), 64'd1);
    check("halt_push",  64'(count), 64'd3);
    out_ready = 1'b1;
    smp(64'h40, 64'h0);
    check("halt_sticky", 64'(halted), 64'd1);
    check("halt_pop_cnt", 64'(count), 64'd2);
    check("halt_pop_pc",  out_pc, 64'h30);
    check("halt_pop_dat", out_data, 64'h33);

    // Capture disabled, halt detection still active
    apply_reset();
    capture_en = 1'b0;
    out_ready  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smp(64'h50 + 64'(4 * i), 64'(i));
    end
    check("nocap_count", 64'(count), 64'd0);
    check("nocap_valid", 64'(out_valid), 64'd0);
    for (int j = 0; j < 4; j++) begin
      smp(64'h70, 64'h7);
    end
    check("nocap_nohalt", 64'(halted), 64'd0);
    smp(64'h70, 64'h7);
    check("nocap_halt",  64'(halted), 64'd1);
    check("nocap_count2", 64'(count), 64'd0);

    // Reset mid-operation with count=5 and overflow set
    apply_reset();
    capture_en = 1'b1;
    out_ready  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      smp(64'h400 + 64'(4 * i), 64'h40 + 64'(i));
    end
    check("pre_count", 64'(count), 64'd8);
    check("pre_drops", 64'(drop_count), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp(64'h420, 64'h0);
    end
    check("pre5_count", 64'(count), 64'd5);
    check("pre5_ovf",   64'(overflow), 64'd1);
    check("pre5_pc",    out_pc, 64'h40C);
    reset = 1'b1;
    #1;
    check_zero("midrst");
    step();
    reset       = 1'b0;
    currentpc   = 64'h0;
    MemtoRegOut = 64'h99;
    capture_en  = 1'b1;
    out_ready   = 1'b0;
    check("post_rst_valid", 64'(out_valid), 64'd0);
    step();
    check("post_first_count", 64'(count), 64'd1);
    check("post_first_valid", 64'(out_valid), 64'd1);
    check("post_first_pc",    out_pc, 64'h0);
    check("post_first_data",  out_data, 64'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
